// File: rtl/adc_sample_sequencer_if.sv
// Signal bundle between the ADC sample sequencer and its surroundings:
// ADC pins, the receiver's parallel word and the captured-sample outputs.
interface adc_sample_sequencer_if #(
  parameter int ANCHO = 16
);
  logic             CS;
  logic             SCLK;
  logic             enable;
  logic [ANCHO-1:0] data_in;
  logic [ANCHO-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;

  modport master (
    input  enable, data_in,
    output CS, SCLK, data_out, data_valid, busy, overrun
  );

  modport slave (
    output enable, data_in,
    input  CS, SCLK, data_out, data_valid, busy, overrun
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC frame generator: drives CS/SCLK for 16-edge conversions plus
// trailing quiet edges, then captures the receiver's word with a valid strobe.
module adc_sample_sequencer #(
  parameter int HALF       = 2,
  parameter int QUIET      = 1,
  parameter int SAMPLE_DIV = 100,
  parameter int ANCHO      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  adc_sample_sequencer_if.master bus
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HALF - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIET - 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, TRAIL, LATCH} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    pcnt_reg;
  logic [HW-1:0]    hcnt_reg, hcnt_next;
  logic [4:0]       ecnt_reg, ecnt_next;
  logic [QW-1:0]    qcnt_reg, qcnt_next;
  logic             cs_reg, cs_next;
  logic             sclk_reg, sclk_next;
  logic             valid_reg;
  logic             overrun_reg;
  logic [ANCHO-1:0] data_reg;
  logic             tick;
  logic             hcnt_done;

  assign tick      = bus.enable && (pcnt_reg == P_LAST);
  assign hcnt_done = (hcnt_reg == H_LAST);

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      pcnt_reg <= '0;
    end else if (pcnt_reg == P_LAST) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

  // CS/SCLK are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    ecnt_next  = ecnt_reg;
    qcnt_next  = qcnt_reg;
    cs_next    = cs_reg;
    sclk_next  = sclk_reg;
    case (state_reg)
      IDLE: begin
        cs_next   = 1'b1;
        sclk_next = 1'b1;
        if (tick) begin
          state_next = START;
          cs_next    = 1'b0;
          hcnt_next  = '0;
          ecnt_next  = '0;
        end
      end
      START: begin
        if (hcnt_done) begin
          state_next = SHIFT;
          hcnt_next  = '0;
          sclk_next  = 1'b0;
          ecnt_next  = ecnt_reg + 1'b1;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      SHIFT: begin
        if (!hcnt_done) begin
          hcnt_next = hcnt_reg + 1'b1;
        end else begin
          hcnt_next = '0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else if (ecnt_reg == 5'd16) begin
            // CS rises together with the first trailing falling edge.
            state_next = TRAIL;
            cs_next    = 1'b1;
            sclk_next  = 1'b0;
            qcnt_next  = '0;
          end else begin
            sclk_next = 1'b0;
            ecnt_next = ecnt_reg + 1'b1;
          end
        end
      end
      TRAIL: begin
        if (!hcnt_done) begin
          hcnt_next = hcnt_reg + 1'b1;
        end else begin
          hcnt_next = '0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else if (qcnt_reg == Q_LAST) begin
            state_next = LATCH;
          end else begin
            qcnt_next = qcnt_reg + 1'b1;
            sclk_next = 1'b0;
          end
        end
      end
      LATCH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cs_next    = 1'b1;
        sclk_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      hcnt_reg    <= '0;
      ecnt_reg    <= '0;
      qcnt_reg    <= '0;
      cs_reg      <= 1'b1;
      sclk_reg    <= 1'b1;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      ecnt_reg  <= ecnt_next;
      qcnt_reg  <= qcnt_next;
      cs_reg    <= cs_next;
      sclk_reg  <= sclk_next;
      valid_reg <= (state_reg == LATCH);
      if (state_reg == LATCH) begin
        data_reg <= bus.data_in;
      end
      // A tick arriving while a frame is in flight is dropped and flagged.
      if (!bus.enable) begin
        overrun_reg <= 1'b0;
      end else if (tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.CS         = cs_reg;
  assign bus.SCLK       = sclk_reg;
  assign bus.data_out   = data_reg;
  assign bus.data_valid = valid_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench: three sequencer instances (defaults, SAMPLE_DIV=50,
// HALF=1/QUIET=2) with a behavioural SCLK-domain receiver on the default one.
module tb_adc_sample_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] adc_word = 16'h0A5C;
  logic [15:0] rx_sr    = '0;
  int          rx_cnt   = 0;

  adc_sample_sequencer_if #(.ANCHO(16)) ia ();
  adc_sample_sequencer_if #(.ANCHO(16)) ib ();
  adc_sample_sequencer_if #(.ANCHO(16)) ic ();

  assign ia.data_in = rx_sr;
  assign ib.data_in = '0;
  assign ic.data_in = '0;

  adc_sample_sequencer #(.HALF(2), .QUIET(1), .SAMPLE_DIV(100), .ANCHO(16)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  adc_sample_sequencer #(.HALF(2), .QUIET(1), .SAMPLE_DIV(50), .ANCHO(16)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );
  adc_sample_sequencer #(.HALF(1), .QUIET(2), .SAMPLE_DIV(100), .ANCHO(16)) u_dut_c (
    .clk(clk), .reset(reset), .bus(ic)
  );

  logic cs_v [3];
  logic sclk_v [3];
  logic dv_v [3];
  assign cs_v[0] = ia.CS;   assign sclk_v[0] = ia.SCLK; assign dv_v[0] = ia.data_valid;
  assign cs_v[1] = ib.CS;   assign sclk_v[1] = ib.SCLK; assign dv_v[1] = ib.data_valid;
  assign cs_v[2] = ic.CS;   assign sclk_v[2] = ic.SCLK; assign dv_v[2] = ic.data_valid;

  int   fall_cnt [3]      = '{default: 0};
  int   fall_cyc [3]      = '{default: 0};
  int   prev_fall_cyc [3] = '{default: 0};
  int   edges [3]         = '{default: 0};
  int   frame_edges [3]   = '{default: 0};
  int   low_len [3]       = '{default: 0};
  int   last_edge [3]     = '{default: 0};
  int   edge_gap [3]      = '{default: 0};
  int   valid_cnt [3]     = '{default: 0};
  int   valid_cyc [3]     = '{default: 0};
  int   cs_sclk_bad [3]   = '{default: 0};
  logic prev_cs [3]       = '{default: 1'b1};
  logic prev_sclk [3]     = '{default: 1'b1};

  // Monitor and receiver model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      rx_cnt = 0;
      rx_sr  = '0;
    end else begin
      if (prev_cs[0] && !ia.CS) rx_cnt = 0;
      if (prev_sclk[0] && !ia.SCLK && !ia.CS && rx_cnt < 16) begin
        rx_sr  = {rx_sr[14:0], adc_word[15 - rx_cnt]};
        rx_cnt = rx_cnt + 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (prev_cs[i] && !cs_v[i]) begin
        fall_cnt[i]++;
        prev_fall_cyc[i] = fall_cyc[i];
        fall_cyc[i]      = cyc;
        edges[i]         = 0;
        if (!prev_sclk[i]) cs_sclk_bad[i]++;
      end
      if (!prev_cs[i] && cs_v[i]) begin
        low_len[i]     = cyc - fall_cyc[i];
        frame_edges[i] = edges[i];
        if (!prev_sclk[i]) cs_sclk_bad[i]++;
      end
      if (prev_sclk[i] && !sclk_v[i] && !cs_v[i]) begin
        edges[i]++;
        edge_gap[i]  = cyc - last_edge[i];
        last_edge[i] = cyc;
      end
      if (dv_v[i]) begin
        valid_cnt[i]++;
        valid_cyc[i] = cyc;
      end
      prev_cs[i]   = cs_v[i];
      prev_sclk[i] = sclk_v[i];
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", tag, got, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int k;
  int f2;
  int f3;

  initial begin
    ia.enable = 1'b0;
    ib.enable = 1'b0;
    ic.enable = 1'b0;

    // Reset state
    reset = 1'b1;
    step(3);
    check("rst_cs",       int'(ia.CS), 1);
    check("rst_sclk",     int'(ia.SCLK), 1);
    check("rst_data_out", int'(ia.data_out), 0);
    check("rst_valid",    int'(ia.data_valid), 0);
    check("rst_busy",     int'(ia.busy), 0);
    check("rst_overrun",  int'(ia.overrun), 0);
    reset = 1'b0;

    // Disabled: nothing happens for 200 cycles
    step(200);
    check("idle_cs",        int'(ia.CS), 1);
    check("idle_sclk",      int'(ia.SCLK), 1);
    check("idle_busy",      int'(ia.busy), 0);
    check("idle_cs_falls",  fall_cnt[0], 0);
    check("idle_valids",    valid_cnt[0], 0);

    // Default frame capturing 0x0A5C
    adc_word  = 16'h0A5C;
    k         = cyc;
    ia.enable = 1'b1;
    for (int n = 0; n < 200 && fall_cnt[0] < 1; n++) step(1);
    check("a_fall_seen",     fall_cnt[0], 1);
    check("a_first_fall_at", fall_cyc[0] - k, 100);
    for (int n = 0; n < 200 && valid_cnt[0] < 1; n++) step(1);
    check("a_valid_count",   valid_cnt[0], 1);
    check("a_cs_low_len",    low_len[0], 66);
    check("a_edges",         frame_edges[0], 16);
    check("a_sclk_period",   edge_gap[0], 4);
    check("a_valid_latency", valid_cyc[0] - fall_cyc[0], 71);
    check("a_data_out",      int'(ia.data_out), 16'h0A5C);
    check("a_valid_pulse",   int'(ia.data_valid), 0);
    $display("frame a1: data_out=0x%04h", ia.data_out);

    adc_word = 16'hC3A5;
    for (int n = 0; n < 200 && fall_cnt[0] < 2; n++) step(1);
    check("a_fall2_seen",    fall_cnt[0], 2);
    check("a_fall_spacing",  fall_cyc[0] - prev_fall_cyc[0], 100);

    // Disable 20 cycles into the second frame: it must still complete
    f2 = fall_cyc[0];
    step(f2 + 20 - cyc);
    ia.enable = 1'b0;
    for (int n = 0; n < 200 && valid_cnt[0] < 2; n++) step(1);
    check("dis_valid_count",   valid_cnt[0], 2);
    check("dis_valid_latency", valid_cyc[0] - f2, 71);
    check("dis_data_out",      int'(ia.data_out), 16'hC3A5);
    $display("frame a2: data_out=0x%04h", ia.data_out);
    step(150);
    check("dis_no_new_fall",   fall_cnt[0], 2);
    check("dis_no_new_valid",  valid_cnt[0], 2);
    check("dis_busy",          int'(ia.busy), 0);
    check("a_cs_while_sclk_hi", cs_sclk_bad[0], 0);

    // Reset 30 cycles into a frame, then a clean frame afterwards
    adc_word  = 16'h3C96;
    ia.enable = 1'b1;
    for (int n = 0; n < 200 && fall_cnt[0] < 3; n++) step(1);
    check("rstmid_fall_seen", fall_cnt[0], 3);
    f3 = fall_cyc[0];
    step(f3 + 30 - cyc);
    check("rstmid_busy_before", int'(ia.busy), 1);
    reset = 1'b1;
    step(1);
    check("rstmid_cs",   int'(ia.CS), 1);
    check("rstmid_sclk", int'(ia.SCLK), 1);
    check("rstmid_busy", int'(ia.busy), 0);
    reset = 1'b0;
    for (int n = 0; n < 250 && fall_cnt[0] < 4; n++) step(1);
    check("rstmid_no_valid", valid_cnt[0], 2);
    for (int n = 0; n < 200 && valid_cnt[0] < 3; n++) step(1);
    check("rstmid_valid_count", valid_cnt[0], 3);
    check("rstmid_edges",       frame_edges[0], 16);
    check("rstmid_data_out",    int'(ia.data_out), 16'h3C96);
    $display("frame a3: data_out=0x%04h", ia.data_out);
    ia.enable = 1'b0;
    step(100);

    // SAMPLE_DIV=50: every second tick dropped, overrun sticky
    k         = cyc;
    ib.enable = 1'b1;
    step(99);
    check("b_overrun_before", int'(ib.overrun), 0);
    check("b_fall_count",     fall_cnt[1], 1);
    check("b_first_fall_at",  fall_cyc[1] - k, 50);
    step(1);
    check("b_overrun_set",    int'(ib.overrun), 1);
    for (int n = 0; n < 300 && fall_cnt[1] < 3; n++) step(1);
    check("b_fall3_seen",     fall_cnt[1], 3);
    check("b_fall_spacing",   fall_cyc[1] - prev_fall_cyc[1], 100);
    check("b_valid_count",    valid_cnt[1], 2);
    check("b_overrun_sticky", int'(ib.overrun), 1);
    ib.enable = 1'b0;
    step(1);
    check("b_overrun_clear",  int'(ib.overrun), 0);
    step(100);
    check("b_busy_end",       int'(ib.busy), 0);
    check("b_cs_while_sclk_hi", cs_sclk_bad[1], 0);

    // HALF=1, QUIET=2
    k         = cyc;
    ic.enable = 1'b1;
    for (int n = 0; n < 200 && fall_cnt[2] < 1; n++) step(1);
    check("c_first_fall_at",  fall_cyc[2] - k, 100);
    for (int n = 0; n < 100 && valid_cnt[2] < 1; n++) step(1);
    check("c_valid_count",    valid_cnt[2], 1);
    check("c_cs_low_len",     low_len[2], 33);
    check("c_valid_latency",  valid_cyc[2] - fall_cyc[2], 38);
    check("c_edges",          frame_edges[2], 16);
    check("c_sclk_period",    edge_gap[2], 2);
    check("c_cs_while_sclk_hi", cs_sclk_bad[2], 0);
    ic.enable = 1'b0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
